// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle 6502 sequencer issuing one-cycle datapath and memory strobes per state
module cpu_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic [1:0] addr_mode,
  input  logic [1:0] instr_size,
  input  logic [7:0] instr_type,
  input  logic       use_alu,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [2:0] reg_dest,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_n,
  input  logic       flag_v,
  output logic [2:0] state,
  output logic       sync,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       pc_inc,
  output logic       pc_load_abs,
  output logic       pc_load_rel,
  output logic       ir_load,
  output logic       op_lo_load,
  output logic       op_hi_load,
  output logic       b_sel_mem,
  output logic       alu_en,
  output logic       reg_we,
  output logic       flags_we,
  output logic       instr_done
);
  typedef enum logic [2:0] {FETCH, LOADIR, DISPATCH, OPLO, OPHI, MEMRD, EXEC} state_e;
  state_e state_q, state_d;
  logic [7:0] br_idx;
  logic is_branch, br_flag, br_set, taken;
  assign state = state_q;
  always_ff @(posedge clk)
    state_q <= rst ? FETCH : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = halt ? FETCH : LOADIR;
      LOADIR:   state_d = DISPATCH;
      DISPATCH: state_d = (instr_size == 2'd1) ? EXEC : OPLO;
      OPLO:     state_d = (instr_size == 2'd3) ? OPHI :
                          (addr_mode == 2'd2 && mem_read) ? MEMRD : EXEC;
      OPHI:     state_d = EXEC;
      MEMRD:    state_d = EXEC;
      EXEC:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end
  // branches come in set/clear pairs on Z, C, N, V; the V pair is ordered clear-then-set
  assign br_idx    = instr_type - 8'd14;
  assign is_branch = instr_type >= 8'd14 && instr_type <= 8'd21;
  assign br_flag   = (br_idx[2:1] == 2'd0) ? flag_z : (br_idx[2:1] == 2'd1) ? flag_c :
                     (br_idx[2:1] == 2'd2) ? flag_n : flag_v;
  assign br_set    = br_idx[0] ^ (br_idx[2:1] != 2'd3);
  assign taken     = is_branch && (br_flag == br_set);
  always_comb begin
    sync        = 1'b0;
    addr_sel    = 1'b0;
    mem_rd      = 1'b0;
    mem_we      = 1'b0;
    pc_inc      = 1'b0;
    pc_load_abs = 1'b0;
    pc_load_rel = 1'b0;
    ir_load     = 1'b0;
    op_lo_load  = 1'b0;
    op_hi_load  = 1'b0;
    b_sel_mem   = 1'b0;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    flags_we    = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          sync   = 1'b1;
          mem_rd = !halt;
          pc_inc = !halt;
        end
        LOADIR: ir_load = 1'b1;
        DISPATCH: begin
          mem_rd = instr_size != 2'd1;
          pc_inc = instr_size != 2'd1;
        end
        OPLO: begin
          op_lo_load = 1'b1;
          mem_rd     = instr_size == 2'd3;
          pc_inc     = instr_size == 2'd3;
        end
        OPHI: op_hi_load = 1'b1;
        MEMRD: begin
          addr_sel = 1'b1;
          mem_rd   = 1'b1;
        end
        EXEC: begin
          instr_done  = 1'b1;
          alu_en      = use_alu;
          b_sel_mem   = addr_mode == 2'd2;
          mem_we      = mem_write;
          addr_sel    = mem_write;
          reg_we      = !mem_write && (reg_dest inside {3'd1, 3'd2, 3'd3, 3'd5});
          flags_we    = (use_alu || instr_type == 8'd0) && reg_dest != 3'd0 && reg_dest != 3'd5;
          pc_load_abs = instr_type == 8'd5;
          pc_load_rel = taken;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed and randomized instructions checked cycle-by-cycle against an instruction-level model
module tb_cpu_control_fsm;
  logic clk = 0, rst = 1, halt = 0;
  logic [1:0] addr_mode = 0, instr_size = 1;
  logic [7:0] instr_type = 0;
  logic use_alu = 0, mem_read = 0, mem_write = 0;
  logic [2:0] reg_dest = 0;
  logic flag_z = 0, flag_c = 0, flag_n = 0, flag_v = 0;
  logic [2:0] state;
  logic sync, addr_sel, mem_rd, mem_we, pc_inc, pc_load_abs, pc_load_rel, ir_load;
  logic op_lo_load, op_hi_load, b_sel_mem, alu_en, reg_we, flags_we, instr_done;
  logic [17:0] obs;
  int checks = 0, failures = 0;

  localparam logic [14:0] SYNC = 15'h4000, ASEL = 15'h2000, MRD = 15'h1000, MWE = 15'h0800,
    PCI = 15'h0400, PABS = 15'h0200, PREL = 15'h0100, IRL = 15'h0080, OPL = 15'h0040,
    OPH = 15'h0020, BSM = 15'h0010, ALU = 15'h0008, RWE = 15'h0004, FWE = 15'h0002, DONE = 15'h0001;

  cpu_control_fsm dut (
    .clk(clk), .rst(rst), .halt(halt), .addr_mode(addr_mode), .instr_size(instr_size),
    .instr_type(instr_type), .use_alu(use_alu), .mem_read(mem_read), .mem_write(mem_write),
    .reg_dest(reg_dest), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .state(state), .sync(sync), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_we(mem_we),
    .pc_inc(pc_inc), .pc_load_abs(pc_load_abs), .pc_load_rel(pc_load_rel), .ir_load(ir_load),
    .op_lo_load(op_lo_load), .op_hi_load(op_hi_load), .b_sel_mem(b_sel_mem), .alu_en(alu_en),
    .reg_we(reg_we), .flags_we(flags_we), .instr_done(instr_done)
  );

  assign obs = {state, sync, addr_sel, mem_rd, mem_we, pc_inc, pc_load_abs, pc_load_rel, ir_load,
                op_lo_load, op_hi_load, b_sel_mem, alu_en, reg_we, flags_we, instr_done};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] ev(input int st, input logic [14:0] s);
    return {3'(st), s};
  endfunction

  function automatic bit branch_taken(input int ty, input logic [3:0] fl);
    logic z, c, n, v;
    {z, c, n, v} = fl;
    case (ty)
      14: return z;
      15: return !z;
      16: return c;
      17: return !c;
      18: return n;
      19: return !n;
      20: return !v;
      21: return v;
      default: return 0;
    endcase
  endfunction

  function automatic logic [14:0] exec_exp(input int mode, ty, alu, mw, rd, input logic [3:0] fl);
    logic [14:0] e;
    e = DONE;
    if (alu != 0) e |= ALU;
    if (mode == 2) e |= BSM;
    if (mw != 0) e |= MWE | ASEL;
    if (mw == 0 && (rd == 1 || rd == 2 || rd == 3 || rd == 5)) e |= RWE;
    if ((alu != 0 || ty == 0) && rd != 0 && rd != 5) e |= FWE;
    if (ty == 5) e |= PABS;
    if (branch_taken(ty, fl)) e |= PREL;
    return e;
  endfunction

  task automatic cyc(input string tag, input logic [17:0] e);
    @(negedge clk);
    check(tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int sz, mode, ty, alu, mr, mw, rd, hc, input logic [3:0] fl,
                     input bit abort);
    instr_size = 2'(sz);
    addr_mode  = 2'(mode);
    instr_type = 8'(ty);
    use_alu    = 1'(alu);
    mem_read   = 1'(mr);
    mem_write  = 1'(mw);
    reg_dest   = 3'(rd);
    {flag_z, flag_c, flag_n, flag_v} = fl;
    for (int i = 0; i < hc; i++) begin
      halt = 1;
      cyc("halt", ev(0, SYNC));
    end
    halt = 0;
    cyc("fetch", ev(0, SYNC | MRD | PCI));
    halt = 1'($urandom);
    cyc("loadir", ev(1, IRL));
    halt = 1'($urandom);
    cyc("dispatch", ev(2, sz == 1 ? 15'h0 : (MRD | PCI)));
    if (sz != 1) begin
      halt = 1'($urandom);
      cyc("oplo", ev(3, OPL | (sz == 3 ? (MRD | PCI) : 15'h0)));
    end
    if (sz == 3) begin
      halt = 1'($urandom);
      cyc("ophi", ev(4, OPH));
    end else if (sz == 2 && mode == 2 && mr != 0) begin
      halt = 1'($urandom);
      cyc("memrd", ev(5, ASEL | MRD));
    end
    halt = 1'($urandom);
    if (abort) begin
      rst = 1;
      cyc("abort_exec", ev(6, 15'h0));
      cyc("abort_hold", ev(0, 15'h0));
      rst = 0;
    end else begin
      cyc("exec", ev(6, exec_exp(mode, ty, alu, mw, rd, fl)));
    end
  endtask

  initial begin
    int r, ty;
    rst = 1;
    @(posedge clk);
    #1;
    halt = 1;
    cyc("reset0", ev(0, 15'h0));
    cyc("reset1", ev(0, 15'h0));
    rst = 0;
    halt = 0;
    // LDA #$00
    run(2, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 0);
    // ADC $zp aborted by reset in EXEC, then normal resume
    run(2, 2, 1, 1, 1, 0, 1, 0, 4'b0101, 1);
    // INC $10 read-modify-write
    run(2, 2, 40, 1, 1, 1, 4, 0, 4'b0000, 0);
    // JMP $1234
    run(3, 3, 5, 0, 0, 0, 0, 0, 4'b1111, 0);
    // BNE taken / not taken
    run(2, 1, 15, 0, 0, 0, 0, 0, 4'b0000, 0);
    run(2, 1, 15, 0, 0, 0, 0, 0, 4'b1000, 0);
    // implied NOP after three halted FETCH cycles
    run(1, 0, 200, 0, 0, 0, 0, 3, 4'b0000, 0);
    // ZP store
    run(2, 2, 2, 0, 0, 1, 4, 0, 4'b0000, 0);
    for (int k = 0; k < 300; k++) begin
      r = $urandom % 4;
      ty = (r == 0) ? 0 : (r == 1) ? 5 : (r == 2) ? int'($urandom_range(14, 21)) : int'($urandom % 256);
      run($urandom_range(1, 3), $urandom_range(0, 3), ty, $urandom % 2, $urandom % 2, $urandom % 2,
          $urandom_range(0, 6), $urandom_range(0, 2), 4'($urandom), ($urandom % 12) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle sequencer for the 6502 softcore. It sits between the opcode decoder and the datapath (PC, IR, operand register, register file, ALU, zero-page RAM). It steps each instruction through fetch, operand fetch, memory read and execute using the decoder's class outputs. It emits one-cycle strobes for every datapath load/write and the memory port.

## Interface
Parameters: none; encodings match the decoder (addr_mode IMPL=0/IMM=1/ZP=2/ABS=3; reg_dest NONE=0/A=1/X=2/Y=3/MEM=4/SP=5/PS=6; instr_type BEQ..BVS=14..21, JMP=5, LDA=0).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- halt  in  1  freeze request; sampled only in FETCH.
- addr_mode  in  2  from decoder.
- instr_size  in  2  from decoder.
- instr_type  in  8  from decoder.
- use_alu  in  1  from decoder.
- mem_read  in  1  from decoder.
- mem_write  in  1  from decoder.
- reg_dest  in  3  from decoder.
- flag_z  in  1  processor status Z.
- flag_c  in  1  processor status C.
- flag_n  in  1  processor status N.
- flag_v  in  1  processor status V.
- state  out  3  current state code.
- sync  out  1  high in FETCH (opcode fetch cycle).
- addr_sel  out  1  memory address source: 0=PC, 1=operand register (zero page).
- mem_rd  out  1  memory read strobe; data valid on mem_rdata the next cycle.
- mem_we  out  1  memory write strobe.
- pc_inc  out  1  PC <= PC+1.
- pc_load_abs  out  1  PC <= {op_hi, op_lo}.
- pc_load_rel  out  1  PC <= PC + sign-extended op_lo.
- ir_load  out  1  IR <= mem_rdata.
- op_lo_load  out  1  operand low register <= mem_rdata.
- op_hi_load  out  1  operand high register <= mem_rdata.
- b_sel_mem  out  1  ALU B / load source: 1=mem_rdata, 0=op_lo.
- alu_en  out  1  ALU result valid this cycle.
- reg_we  out  1  write the register selected by reg_dest.
- flags_we  out  1  update N/Z (and C/V for ALU ops).
- instr_done  out  1  one-cycle pulse in the final cycle of every instruction.

## Operation
States: FETCH=0, LOADIR=1, DISPATCH=2, OPLO=3, OPHI=4, MEMRD=5, EXEC=6.
- FETCH: if halt, remain and assert nothing but sync. Otherwise assert addr_sel=0, mem_rd, pc_inc, then go to LOADIR.
- LOADIR: ir_load, then go to DISPATCH. Decoder inputs are valid from DISPATCH onward.
- DISPATCH:
  - instr_size==1: go to EXEC.
  - Otherwise: assert addr_sel=0, mem_rd, pc_inc, then go to OPLO.
- OPLO: op_lo_load.
  - instr_size==3: also assert addr_sel=0, mem_rd, pc_inc, then go to OPHI.
  - Else if addr_mode==ZP and mem_read: go to MEMRD.
  - Else: go to EXEC.
- OPHI: op_hi_load, then go to EXEC.
- MEMRD: addr_sel=1, mem_rd, then go to EXEC.
- EXEC: instr_done, then go to FETCH. In this state:
  - alu_en=use_alu.
  - b_sel_mem=(addr_mode==ZP).
  - mem_we=mem_write, with addr_sel=1. Store and INC/DEC write the ALU result or register to op_lo.
  - reg_we=1 when reg_dest∈{A,X,Y,SP} and mem_write=0.
  - flags_we=1 when (use_alu or instr_type==LDA) and reg_dest∉{SP,NONE}.
  - pc_load_abs when instr_type==JMP.
  - pc_load_rel when the branch condition is true: BEQ Z=1, BNE Z=0, BCS C=1, BCC C=0, BMI N=1, BPL N=0, BVS V=1, BVC V=0.
- Branch offset base is the PC after the operand byte.
- Unknown opcodes (size 1, reg_dest NONE, no ALU) execute as a 4-cycle NOP with no side effects.
- Outputs are decoded from state plus decoder inputs. Every strobe is 0 outside the states listed above.

## Timing
- Reset: state=FETCH; every output except state/sync is 0 during the reset cycle, and sync=0 while rst=1. The first fetch strobe is in the cycle after rst falls (if halt=0).
- Cycles per instruction:
  - implied: 4
  - immediate, ZP store, branch: 5
  - ZP read (LDA/ORA/CMP/INC...): 6
  - JMP: 6
- Read-modify-write (INC/DEC ZP): read in MEMRD, ALU and mem_we in the same EXEC cycle.
- rst in any state wins: next state is FETCH, and no strobe for the aborted instruction is asserted in the reset cycle.
- halt is ignored outside FETCH; an instruction in flight always completes.

## Test plan
- Reset: hold rst 2 cycles in mid-EXEC of an ADC -> state=0, all strobes 0, no reg_we. The next fetch occurs at the PC value held by the datapath.
- LDA #$00 (A9 00) -> states 0,1,2,3,6. pc_inc in cycles 0 and 2. reg_we=1 and flags_we=1 in cycle 4 with b_sel_mem=0. instr_done in cycle 4.
- INC $10 (E6 10) -> states 0,1,2,3,5,6. MEMRD has mem_rd with addr_sel=1. EXEC has alu_en=1, mem_we=1 and reg_we=0.
- JMP $1234 (4C 34 12) -> three pc_inc pulses, op_lo_load then op_hi_load, pc_load_abs in EXEC, 6 cycles total.
- BNE with flag_z=0 -> pc_load_rel=1. With flag_z=1 -> pc_load_rel=0. Both take 5 cycles.
- halt=1 in FETCH for 3 cycles -> state stays 0, mem_rd=0, pc_inc=0. halt asserted during OPLO has no effect.
